matvec_ctrl: RTL
================

# matvec_ctrl

Sequencing controller for the `matvec_mul` adder-tree datapath.
- Holds the R×C weight matrix, loaded row by row from an AXI-Stream weight port.
- Feeds x vectors from an AXI-Stream input into the datapath.
- Tracks in-flight vectors with a valid shift register and drives `cen` to stall the whole pipeline under output backpressure.
- Sits between the UART/AXI-Stream front end and `matvec_mul`. Both are instantiated side by side in the parent.

## Interface
- `R`, 8: matrix rows.
- `C`, 8: matrix columns.
- `W_X`, 8: x element width.
- `W_K`, 8: weight width.
- `DEPTH`, localparam: `$clog2(C)`.
- `W_Y`, localparam: `W_X+W_K+DEPTH`.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `s_k_valid` / `s_k_ready` in/out 1: weight-row stream handshake.
- `s_k_data` in C×W_K: one signed weight row per beat; element j is at `[j]`.
- `s_x_valid` / `s_x_ready` in/out 1: x vector stream handshake.
- `s_x_data` in C×W_X: signed x vector.
- `m_y_valid` / `m_y_ready` out/in 1: result stream handshake.
- `m_y_data` out R×W_Y: equals `mv_y`.
- `mv_cen` out 1: datapath clock enable.
- `mv_k` out R×C×W_K: weight bank contents.
- `mv_x` out C×W_X: equals `s_x_data`.
- `mv_y` in R×W_Y: datapath result.
- `weights_ok` out 1: high in RUN and DRAIN.

## Operation
- States:
  - IDLE: no valid weights.
  - LOAD: accepting rows.
  - RUN: computing.
  - DRAIN: flushing before a reload.
- Control signals:
  - `s_k_ready` = (IDLE or LOAD).
  - `s_x_ready` = RUN && `mv_cen`.
  - `mv_cen` = !(`vld[DEPTH]` && !`m_y_ready`).
- Weight load:
  - `row_cnt` resets to 0.
  - Each accepted k beat writes bank row `row_cnt` and increments it.
  - IDLE→LOAD on the first beat.
  - The beat at `row_cnt==R-1` moves to RUN and clears `row_cnt`.
  - If R==1, the first beat goes IDLE→RUN directly.
- Compute:
  - On each `mv_cen`-high edge, `vld` shifts (DEPTH+1 bits) and `vld[0]` <= x accepted.
  - `m_y_valid` = `vld[DEPTH]`.
  - With `mv_cen` low, `vld`, the datapath and `mv_y` all hold, so `m_y_data` stays stable while `m_y_valid` is high.
- Reload:
  - `s_k_valid` high in RUN moves to DRAIN. `s_k_ready` stays 0 in RUN.
  - DRAIN accepts no x.
  - DRAIN→IDLE when `vld`==0, i.e. the last result has been handshaken.
  - IDLE then accepts the pending row as row 0.
- Arithmetic: signed and full-width, with no truncation in the controller. `W_Y` covers the C-term sum.
- Reset: asynchronous. Forces state IDLE, `vld`=0, `row_cnt`=0 and bank=0.

## Timing
- Reset values:
  - `s_k_ready`=1
  - `s_x_ready`=0
  - `m_y_valid`=0
  - `mv_cen`=1
  - `weights_ok`=0
  - `mv_k`=0
- Latency: an x accepted in cycle t gives `m_y_valid`=1 in cycle t+DEPTH+1 (4 for C=8), with no stalls.
- Throughput: 1 vector/cycle while `m_y_ready`=1. Bubbles propagate without stalling.
- Backpressure: `m_y_valid && !m_y_ready` drops `mv_cen` and `s_x_ready` combinationally in the same cycle. Intermediate results are neither lost nor duplicated.
- Simultaneous `s_x_valid` and `s_k_valid` in RUN: the x is accepted if `mv_cen`=1. The state enters DRAIN next cycle and the x completes normally.
- DRAIN with output stalled: stays in DRAIN indefinitely and holds the data.
- Reset mid-operation: in-flight vectors are discarded and `m_y_valid` drops immediately. Weights must be reloaded.
- `s_k_data` / `s_x_data` are sampled only on handshake. The bank updates at the handshake edge and `mv_k` reflects it next cycle.

## Structure
- Package `matvec_pkg`:
  - state enum `mv_state_e` {IDLE, LOAD, RUN, DRAIN}
  - default R/C/W_X/W_K constants
  - `W_Y` derivation function
- No sub-module inside `matvec_ctrl`. The weight bank, `vld` shift register and FSM are inline.
- Parent `matvec_top` instantiates `matvec_ctrl` and `matvec_mul` and wires the `mv_*` ports.

## Test plan
- Load identity (k[i][i]=1, else 0) as 8 rows, then send x={1..8}. Expect y={1..8} exactly 4 cycles after acceptance; `weights_ok` rises after row 8.
- Load all -128 weights with x all -128. Expect every y = 8×16384 = 131072, with no overflow at `W_Y`=19.
- Stream 16 vectors back-to-back with `m_y_ready`=1. Expect 16 results in order on 16 consecutive cycles starting 4 cycles after the first accept.
- Random `m_y_ready` at 50% over 100 vectors. Expect no drop or duplicate, results matching the model, and `m_y_data` stable during stalls.
- With 3 vectors in flight, assert `s_k_valid`. Expect `s_x_ready`=0, all 3 results delivered, then IDLE. The new rows load and subsequent y use the new weights.
- Assert `rstn`=0 with 2 vectors in flight. Expect `m_y_valid`=0 immediately and `s_k_ready`=1. After release, x is refused until 8 rows have been loaded.

Source files
------------

// File: rtl/matvec_pkg.sv
// matvec_pkg: shared FSM encoding, default dimensions and result-width helper
// for the matvec controller and datapath.
package matvec_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} mv_state_e;
   localparam int R_DEF   = 8;
   localparam int C_DEF   = 8;
   localparam int W_X_DEF = 8;
   localparam int W_K_DEF = 8;
   function automatic int calc_w_y(input int w_x, input int w_k, input int c);
      return w_x + w_k + $clog2(c);
   endfunction
endpackage

// File: rtl/matvec_ctrl.sv
// matvec_ctrl: weight bank, in-flight vector tracking and pipeline stall
// control for the matvec_mul adder-tree datapath.
module matvec_ctrl
   import matvec_pkg::*;
#(
   parameter int R = R_DEF,
   parameter int C = C_DEF,
   parameter int W_X = W_X_DEF,
   parameter int W_K = W_K_DEF,
   localparam int DEPTH = $clog2(C),
   localparam int W_Y = calc_w_y(W_X, W_K, C)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               s_k_valid,
   output logic               s_k_ready,
   input  logic [C*W_K-1:0]   s_k_data,
   input  logic               s_x_valid,
   output logic               s_x_ready,
   input  logic [C*W_X-1:0]   s_x_data,
   output logic               m_y_valid,
   input  logic               m_y_ready,
   output logic [R*W_Y-1:0]   m_y_data,
   output logic               mv_cen,
   output logic [R*C*W_K-1:0] mv_k,
   output logic [C*W_X-1:0]   mv_x,
   input  logic [R*W_Y-1:0]   mv_y,
   output logic               weights_ok
);
   localparam int W_R = (R > 1) ? $clog2(R) : 1;
   localparam int W_V = DEPTH + 1;

   mv_state_e          r_state, w_next;
   logic [W_V-1:0]     r_vld;
   logic [W_R-1:0]     r_row_cnt;
   logic [R*C*W_K-1:0] r_bank;
   logic               w_cen, w_k_fire, w_x_fire, w_last_row;

   // A result waiting on a stalled consumer freezes the whole pipeline.
   assign w_cen      = !(r_vld[DEPTH] && !m_y_ready);
   assign w_k_fire   = s_k_valid && s_k_ready;
   assign w_x_fire   = s_x_valid && s_x_ready;
   assign w_last_row = r_row_cnt == W_R'(R - 1);

   assign s_k_ready  = (r_state == IDLE) || (r_state == LOAD);
   assign s_x_ready  = (r_state == RUN) && w_cen;
   assign weights_ok = (r_state == RUN) || (r_state == DRAIN);
   assign m_y_valid  = r_vld[DEPTH];
   assign m_y_data   = mv_y;
   assign mv_cen     = w_cen;
   assign mv_k       = r_bank;
   assign mv_x       = s_x_data;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, LOAD: if (w_k_fire) w_next = w_last_row ? RUN : LOAD;
         RUN:        if (s_k_valid) w_next = DRAIN;
         DRAIN:      if (r_vld == '0) w_next = IDLE;
         default:    w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_vld     <= '0;
         r_row_cnt <= '0;
         r_bank    <= '0;
      end else begin
         r_state <= w_next;
         if (w_cen) r_vld <= W_V'({r_vld, w_x_fire});
         if (w_k_fire) begin
            r_bank[int'(r_row_cnt)*C*W_K +: C*W_K] <= s_k_data;
            r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
         end
      end
   end
endmodule
